// File: rtl/pb_conditioner.sv
// Two-channel pushbutton front-end: 2-FF synchronizer, debouncer and
// auto-repeat FSM per channel, with an inc/dec interlock. Channel 0 is
// increment, channel 1 is decrement.
module pb_conditioner #(
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter int unsigned REPEAT_EN     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    output logic pb_inc,
    output logic pb_dec,
    output logic inc_level,
    output logic dec_level
);

    localparam int unsigned CW   = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    level;
    logic [1:0]    level_nxt_c;
    logic [CW-1:0] cnt [2];
    logic [CW-1:0] cnt_nxt_c [2];
    state_t        state [2];
    state_t        state_nxt_c [2];
    logic [TW-1:0] timer [2];
    logic [TW-1:0] timer_nxt_c [2];
    logic [1:0]    pulse_c;
    logic          lock_c;

    assign inc_level = level[0];
    assign dec_level = level[1];

    // Synchronizer chain and debounced level / stability counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= '0;
            s2    <= '0;
            level <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= {btn_dec_raw, btn_inc_raw};
            s2    <= s1;
            level <= level_nxt_c;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= cnt_nxt_c[i];
            end
        end
    end

    // Debounce: accept s2 after DEB_CYCLES consecutive cycles of disagreement
    always_comb begin
        level_nxt_c = level;
        for (int i = 0; i < 2; i++) begin
            cnt_nxt_c[i] = '0;
            if (s2[i] != level[i]) begin
                if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    level_nxt_c[i] = s2[i];
                end else begin
                    cnt_nxt_c[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Interlock while both levels are (or are about to be) high together
    assign lock_c = (level[0] & level[1]) | (level_nxt_c[0] & level_nxt_c[1]);

    // Repeat FSM state and timer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_nxt_c[i];
                timer[i] <= timer_nxt_c[i];
            end
        end
    end

    // Repeat FSM next-state, timer and pulse decode; level fall beats expiry
    always_comb begin
        pulse_c = '0;
        for (int i = 0; i < 2; i++) begin
            state_nxt_c[i] = state[i];
            timer_nxt_c[i] = timer[i];
            if (lock_c) begin
                state_nxt_c[i] = level_nxt_c[i] ? HOLD : IDLE;
                timer_nxt_c[i] = '0;
            end else if (level[i] && !level_nxt_c[i]) begin
                state_nxt_c[i] = IDLE;
                timer_nxt_c[i] = '0;
            end else begin
                case (state[i])
                    IDLE: begin
                        timer_nxt_c[i] = '0;
                        if (level_nxt_c[i] && !level[i]) begin
                            state_nxt_c[i] = HOLD;
                            pulse_c[i]     = 1'b1;
                        end
                    end
                    HOLD: begin
                        if (REPEAT_EN != 0) begin
                            if (timer[i] == TW'(REPEAT_DELAY - 1)) begin
                                state_nxt_c[i] = REPEAT;
                                timer_nxt_c[i] = '0;
                                pulse_c[i]     = 1'b1;
                            end else begin
                                timer_nxt_c[i] = timer[i] + TW'(1);
                            end
                        end
                    end
                    REPEAT: begin
                        if (timer[i] == TW'(REPEAT_PERIOD - 1)) begin
                            timer_nxt_c[i] = '0;
                            pulse_c[i]     = 1'b1;
                        end else begin
                            timer_nxt_c[i] = timer[i] + TW'(1);
                        end
                    end
                    default: begin
                        state_nxt_c[i] = IDLE;
                        timer_nxt_c[i] = '0;
                    end
                endcase
            end
        end
    end

    // Registered step pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pb_inc <= 1'b0;
            pb_dec <= 1'b0;
        end else begin
            pb_inc <= pulse_c[0];
            pb_dec <= pulse_c[1];
        end
    end

endmodule
